// File: rtl/regfile_pkg.sv
// regfile_pkg: shared regfile address width, register count and write-back entry layout
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int WB_DATAWIDTH = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATAWIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-first match of one read address against the pending write-back entries
module wb_fwd_match import regfile_pkg::*; #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addrs,
  input  logic [DEPTH-1:0][DATAWIDTH-1:0]  datas,
  input  logic [$clog2(DEPTH)-1:0]         head,
  input  logic [$clog2(DEPTH):0]           count,
  input  logic [REG_ADDR_W-1:0]            raddr,
  output logic                             hit,
  output logic [DATAWIDTH-1:0]             data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  logic blocked;
  assign blocked = DROP_ZERO != 0 && raddr == '0;
  // walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    hit = 1'b0;
    data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(count) && addrs[idx] == raddr && !blocked) begin
        hit = 1'b1;
        data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of datapath results draining one per cycle into the regfile write port
// Define WB_BYPASS_EN to forward youngest pending values to the snooped read addresses.
module regfile_wb_queue import regfile_pkg::*; #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_W-1:0]   in_reg,
  input  logic [DATAWIDTH-1:0]    in_data,
  input  logic                    stall,
  output logic                    write,
  output logic [REG_ADDR_W-1:0]   writeReg,
  output logic [DATAWIDTH-1:0]    writeData,
  input  logic [REG_ADDR_W-1:0]   readReg1,
  input  logic [REG_ADDR_W-1:0]   readReg2,
  output logic                    fwd1_hit,
  output logic [DATAWIDTH-1:0]    fwd1_data,
  output logic                    fwd2_hit,
  output logic [DATAWIDTH-1:0]    fwd2_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATAWIDTH-1:0] data_q;
  logic push, store;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[PW-1:0] == rd_ptr[PW-1:0] && wr_ptr[PW] != rd_ptr[PW];
  assign in_ready = !full;
  assign push = in_valid && in_ready;
  // register-0 results complete the handshake but are never stored
  assign store = push && !(DROP_ZERO != 0 && in_reg == '0);
  assign write = !empty && !stall;
  assign writeReg = addr_q[rd_ptr[PW-1:0]];
  assign writeData = data_q[rd_ptr[PW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (write) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[wr_ptr[PW-1:0]] <= in_reg;
      data_q[wr_ptr[PW-1:0]] <= in_data;
    end
  end
`ifdef WB_BYPASS_EN
  wb_fwd_match #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .DROP_ZERO(DROP_ZERO)) u_fwd1 (
    .addrs(addr_q), .datas(data_q), .head(rd_ptr[PW-1:0]), .count(count),
    .raddr(readReg1), .hit(fwd1_hit), .data(fwd1_data)
  );
  wb_fwd_match #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .DROP_ZERO(DROP_ZERO)) u_fwd2 (
    .addrs(addr_q), .datas(data_q), .head(rd_ptr[PW-1:0]), .count(count),
    .raddr(readReg2), .hit(fwd2_hit), .data(fwd2_data)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{readReg1, readReg2};
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif
endmodule
